// File: rtl/rs_pkg.sv
// Shared types, defaults and address-legality helper for the register status table.
package rs_pkg;

    localparam int TAG_W    = 4;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rs_entry_t;

    // Register 0 is hardwired not-busy; addresses past the table are ignored.
    function automatic logic rs_legal(input int unsigned addr, input int unsigned num_regs);
        return (addr != 0) && (addr < num_regs);
    endfunction

endpackage

// File: rtl/rs_lookup_port.sv
// One combinational source lookup with same-cycle commit bypass.
module rs_lookup_port
    import rs_pkg::*;
#(
    parameter int NUM_REGS = rs_pkg::NUM_REGS,
    parameter int TAG_W    = rs_pkg::TAG_W,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]             addr,
    input  logic [NUM_REGS-1:0]       busy_vec,
    input  logic [NUM_REGS*TAG_W-1:0] tag_vec,
    input  logic                      cmt_en,
    input  logic [AW-1:0]             cmt_addr,
    input  logic [TAG_W-1:0]          cmt_tag,
    output logic                      busy,
    output logic [TAG_W-1:0]          tag
);

    logic             ent_busy;
    logic [TAG_W-1:0] ent_tag;

    always_comb begin
        ent_busy = 1'b0;
        ent_tag  = '0;
        if (rs_legal(32'(addr), NUM_REGS)) begin
            ent_busy = busy_vec[addr];
            ent_tag  = tag_vec[32'(addr)*TAG_W +: TAG_W];
        end
        // A commit that would retire this producer this cycle is seen as already done.
        busy = ent_busy && !(cmt_en && (cmt_addr == addr) && (cmt_tag == ent_tag));
        tag  = busy ? ent_tag : '0;
    end

endmodule

// File: rtl/reg_status_table.sv
// Architectural register -> youngest in-flight ROB tag map with lookup, rename, commit and flush.
module reg_status_table
    import rs_pkg::*;
#(
    parameter int NUM_REGS = rs_pkg::NUM_REGS,
    parameter int TAG_W    = rs_pkg::TAG_W,
    parameter int NUM_READ = 2,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          lk_req,
    input  logic [NUM_READ*AW-1:0]        lk_addr,
    output logic                          lk_valid,
    output logic [NUM_READ-1:0]           lk_busy,
    output logic [NUM_READ*TAG_W-1:0]     lk_tag,
    input  logic                          ren_en,
    input  logic [AW-1:0]                 ren_addr,
    input  logic [TAG_W-1:0]              ren_tag,
    input  logic                          cmt_en,
    input  logic [AW-1:0]                 cmt_addr,
    input  logic [TAG_W-1:0]              cmt_tag,
    output logic [$clog2(NUM_REGS+1)-1:0] busy_count
);

    localparam int CW = $clog2(NUM_REGS+1);

    logic [NUM_REGS-1:0]       busy_reg;
    logic [TAG_W-1:0]          tag_reg [NUM_REGS];
    logic [NUM_REGS*TAG_W-1:0] tag_flat;
    logic [NUM_REGS-1:0]       ren_hit;
    logic [NUM_REGS-1:0]       cmt_hit;
    logic                      ren_legal;
    logic                      cmt_legal;
    logic                      inc;
    logic                      dec;
    logic [CW-1:0]             count_reg;
    logic [CW-1:0]             count_next;

    logic                      lk_valid_reg;
    logic [NUM_READ-1:0]       lk_busy_reg;
    logic [NUM_READ*TAG_W-1:0] lk_tag_reg;
    logic [NUM_READ-1:0]       rd_busy;
    logic [NUM_READ*TAG_W-1:0] rd_tag;

    assign ren_legal = rs_legal(32'(ren_addr), NUM_REGS);
    assign cmt_legal = rs_legal(32'(cmt_addr), NUM_REGS);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            assign tag_flat[gi*TAG_W +: TAG_W] = tag_reg[gi];
            assign ren_hit[gi] = ren_en && ren_legal && (32'(ren_addr) == gi);
            assign cmt_hit[gi] = cmt_en && cmt_legal && (32'(cmt_addr) == gi)
                                 && busy_reg[gi] && (tag_reg[gi] == cmt_tag);

            // Rename beats a same-register commit: the new producer owns the entry.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    busy_reg[gi] <= 1'b0;
                    tag_reg[gi]  <= '0;
                end else if (ren_hit[gi]) begin
                    busy_reg[gi] <= 1'b1;
                    tag_reg[gi]  <= ren_tag;
                end else if (cmt_hit[gi]) begin
                    busy_reg[gi] <= 1'b0;
                    tag_reg[gi]  <= '0;
                end
            end
        end

        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_port
            rs_lookup_port #(
                .NUM_REGS (NUM_REGS),
                .TAG_W    (TAG_W),
                .AW       (AW)
            ) u_port (
                .addr     (lk_addr[gi*AW +: AW]),
                .busy_vec (busy_reg),
                .tag_vec  (tag_flat),
                .cmt_en   (cmt_en),
                .cmt_addr (cmt_addr),
                .cmt_tag  (cmt_tag),
                .busy     (rd_busy[gi]),
                .tag      (rd_tag[gi*TAG_W +: TAG_W])
            );
        end
    endgenerate

    // Count tracks the busy population exactly: a rename onto an already-busy
    // register adds nothing, and a commit cancelled by a same-register rename removes nothing.
    assign inc        = |(ren_hit & ~busy_reg);
    assign dec        = |(cmt_hit & ~ren_hit);
    assign count_next = count_reg + CW'(inc) - CW'(dec);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg    <= '0;
            lk_valid_reg <= 1'b0;
            lk_busy_reg  <= '0;
            lk_tag_reg   <= '0;
        end else begin
            count_reg    <= count_next;
            lk_valid_reg <= lk_req;
            if (lk_req) begin
                lk_busy_reg <= rd_busy;
                lk_tag_reg  <= rd_tag;
            end
        end
    end

    assign lk_valid   = lk_valid_reg;
    assign lk_busy    = lk_busy_reg;
    assign lk_tag     = lk_tag_reg;
    assign busy_count = count_reg;

endmodule

// File: tb/tb_reg_status_table.sv
// Directed, table-driven checks of the register status table, plus reset and out-of-range corner cases.
module tb_reg_status_table;

    localparam int AW = 5;
    localparam int TW = 4;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           lk_req;
    logic [2*AW-1:0] lk_addr;
    logic           lk_valid;
    logic [1:0]     lk_busy;
    logic [2*TW-1:0] lk_tag;
    logic           ren_en;
    logic [AW-1:0]  ren_addr;
    logic [TW-1:0]  ren_tag;
    logic           cmt_en;
    logic [AW-1:0]  cmt_addr;
    logic [TW-1:0]  cmt_tag;
    logic [5:0]     busy_count;

    // Second instance with a table smaller than the address space.
    logic           s_lk_req;
    logic [2*AW-1:0] s_lk_addr;
    logic           s_lk_valid;
    logic [1:0]     s_lk_busy;
    logic [2*TW-1:0] s_lk_tag;
    logic           s_ren_en;
    logic [AW-1:0]  s_ren_addr;
    logic [TW-1:0]  s_ren_tag;
    logic           s_cmt_en;
    logic [AW-1:0]  s_cmt_addr;
    logic [TW-1:0]  s_cmt_tag;
    logic [4:0]     s_busy_count;

    int checks = 0;
    int errors = 0;

    reg_status_table dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lk_req(lk_req), .lk_addr(lk_addr), .lk_valid(lk_valid), .lk_busy(lk_busy), .lk_tag(lk_tag),
        .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
        .cmt_en(cmt_en), .cmt_addr(cmt_addr), .cmt_tag(cmt_tag),
        .busy_count(busy_count)
    );

    reg_status_table #(.NUM_REGS(20)) dut_small (
        .clk(clk), .rst(rst), .flush(1'b0),
        .lk_req(s_lk_req), .lk_addr(s_lk_addr), .lk_valid(s_lk_valid), .lk_busy(s_lk_busy), .lk_tag(s_lk_tag),
        .ren_en(s_ren_en), .ren_addr(s_ren_addr), .ren_tag(s_ren_tag),
        .cmt_en(s_cmt_en), .cmt_addr(s_cmt_addr), .cmt_tag(s_cmt_tag),
        .busy_count(s_busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           ren;
        logic [AW-1:0]  ra;
        logic [TW-1:0]  rt;
        logic           cmt;
        logic [AW-1:0]  ca;
        logic [TW-1:0]  ct;
        logic           lk;
        logic [AW-1:0]  a0;
        logic [AW-1:0]  a1;
        logic           fl;
        logic           e_valid;
        logic [1:0]     e_busy;
        logic [2*TW-1:0] e_tag;
        int             e_count;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_main();
        flush = 0; lk_req = 0; lk_addr = '0;
        ren_en = 0; ren_addr = '0; ren_tag = '0;
        cmt_en = 0; cmt_addr = '0; cmt_tag = '0;
    endtask

    task automatic idle_small();
        s_lk_req = 0; s_lk_addr = '0;
        s_ren_en = 0; s_ren_addr = '0; s_ren_tag = '0;
        s_cmt_en = 0; s_cmt_addr = '0; s_cmt_tag = '0;
    endtask

    task automatic check_main(input string tag_name, input int idx, input logic ev, input logic [1:0] eb,
                              input logic [2*TW-1:0] et, input int ec);
        chk({tag_name, "_valid"}, idx, 32'(lk_valid), 32'(ev));
        chk({tag_name, "_busy"}, idx, 32'(lk_busy), 32'(eb));
        chk({tag_name, "_tag"}, idx, 32'(lk_tag), 32'(et));
        chk({tag_name, "_count"}, idx, 32'(busy_count), 32'(ec));
        $display("%s %0d: valid=%0b busy=%b tag=%h count=%0d", tag_name, idx, lk_valid, lk_busy, lk_tag, busy_count);
    endtask

    initial begin
        //        ren ra rt  cmt ca ct  lk a0 a1 fl  valid busy   tag    cnt
        vecs[0]  = '{0, 0, 0,  0, 0, 0,  1, 3, 5, 0,  1, 2'b00, 8'h00, 0};
        vecs[1]  = '{1, 3, 7,  0, 0, 0,  0, 0, 0, 0,  0, 2'b00, 8'h00, 1};
        vecs[2]  = '{0, 0, 0,  0, 0, 0,  1, 3, 0, 0,  1, 2'b01, 8'h07, 1};
        vecs[3]  = '{1, 3, 9,  0, 0, 0,  0, 0, 0, 0,  0, 2'b01, 8'h07, 1};
        vecs[4]  = '{0, 0, 0,  1, 3, 7,  1, 3, 0, 0,  1, 2'b01, 8'h09, 1};
        vecs[5]  = '{0, 0, 0,  1, 3, 9,  0, 0, 0, 0,  0, 2'b01, 8'h09, 0};
        vecs[6]  = '{0, 0, 0,  0, 0, 0,  1, 3, 0, 0,  1, 2'b00, 8'h00, 0};
        vecs[7]  = '{1, 4, 5,  0, 0, 0,  0, 0, 0, 0,  0, 2'b00, 8'h00, 1};
        vecs[8]  = '{1, 4, 2,  1, 4, 5,  1, 4, 0, 0,  1, 2'b00, 8'h00, 1};
        vecs[9]  = '{0, 0, 0,  0, 0, 0,  1, 4, 0, 0,  1, 2'b01, 8'h02, 1};
        vecs[10] = '{1, 0, 1,  0, 0, 0,  0, 0, 0, 0,  0, 2'b01, 8'h02, 1};
        vecs[11] = '{0, 0, 0,  0, 0, 0,  1, 0, 4, 0,  1, 2'b10, 8'h20, 1};
        vecs[12] = '{1, 5, 3,  0, 0, 0,  0, 0, 0, 0,  0, 2'b10, 8'h20, 2};
        vecs[13] = '{1, 6, 4,  0, 0, 0,  0, 0, 0, 0,  0, 2'b10, 8'h20, 3};
        vecs[14] = '{1, 6, 8,  0, 0, 0,  1, 4, 5, 1,  0, 2'b00, 8'h00, 0};
        vecs[15] = '{0, 0, 0,  0, 0, 0,  1, 5, 6, 0,  1, 2'b00, 8'h00, 0};
        vecs[16] = '{1, 6, 1,  0, 0, 0,  1, 6, 6, 0,  1, 2'b00, 8'h00, 1};
        vecs[17] = '{0, 0, 0,  1, 7, 0,  0, 0, 0, 0,  0, 2'b00, 8'h00, 1};

        idle_main();
        idle_small();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_main("reset", 0, 1'b0, 2'b00, 8'h00, 0);
        chk("small_reset_count", 0, 32'(s_busy_count), 32'd0);

        for (int i = 0; i < 18; i++) begin
            ren_en = vecs[i].ren; ren_addr = vecs[i].ra; ren_tag = vecs[i].rt;
            cmt_en = vecs[i].cmt; cmt_addr = vecs[i].ca; cmt_tag = vecs[i].ct;
            lk_req = vecs[i].lk;  lk_addr = {vecs[i].a1, vecs[i].a0};
            flush  = vecs[i].fl;
            @(posedge clk);
            #1;
            idle_main();
            check_main("vec", i, vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_tag, vecs[i].e_count);
        end

        // r6 is busy here; reset in the same cycle as a rename must win.
        ren_en = 1; ren_addr = 5'd9; ren_tag = 4'd3; lk_req = 1; lk_addr = {5'd6, 5'd9};
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        idle_main();
        check_main("rst_mid", 0, 1'b0, 2'b00, 8'h00, 0);
        lk_req = 1; lk_addr = {5'd9, 5'd6};
        @(posedge clk);
        #1;
        idle_main();
        check_main("rst_after", 0, 1'b1, 2'b00, 8'h00, 0);

        // Out-of-range rename/commit against a 20-entry table.
        s_ren_en = 1; s_ren_addr = 5'd25; s_ren_tag = 4'd1;
        @(posedge clk);
        #1;
        idle_small();
        chk("oob_ren_count", 0, 32'(s_busy_count), 32'd0);
        s_ren_en = 1; s_ren_addr = 5'd19; s_ren_tag = 4'd2;
        @(posedge clk);
        #1;
        idle_small();
        chk("last_ren_count", 0, 32'(s_busy_count), 32'd1);
        s_cmt_en = 1; s_cmt_addr = 5'd25; s_cmt_tag = 4'd1;
        s_lk_req = 1; s_lk_addr = {5'd19, 5'd25};
        @(posedge clk);
        #1;
        idle_small();
        chk("oob_lk_valid", 0, 32'(s_lk_valid), 32'd1);
        chk("oob_lk_busy", 0, 32'(s_lk_busy), 32'b10);
        chk("oob_lk_tag", 0, 32'(s_lk_tag), 32'h20);
        chk("oob_cmt_count", 0, 32'(s_busy_count), 32'd1);
        $display("small: valid=%0b busy=%b tag=%h count=%0d", s_lk_valid, s_lk_busy, s_lk_tag, s_busy_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
